dlat_bank_writer: RTL and testbench



---
 rtl/dlat_bank_writer.sv | 121 ++++++++++++
 tb/tb_dlat_bank_writer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dlat_bank_writer.sv
// Write sequencer for a bank of transparent D-latches sharing one data bus.
// Each accepted write runs data-setup, a single-row gate pulse, then data-hold.
module dlat_bank_writer #(
    parameter int DW        = 8,
    parameter int ROWS      = 16,
    parameter int AW        = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_addr,
    input  logic [DW-1:0]   in_data,
    output logic [DW-1:0]   LAT_D,
    output logic [ROWS-1:0] LAT_EN,
    output logic            busy,
    output logic            done,
    output logic            err
);

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || ROWS > (1 << AW)) begin : g_param_check
        $error("dlat_bank_writer: phase lengths must be >= 1 and ROWS <= 2**AW");
    end

    localparam int MAX_CYC_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC    = (MAX_CYC_SP > HOLD_CYC) ? MAX_CYC_SP : HOLD_CYC;
    localparam int CW         = $clog2(MAX_CYC + 1);
    localparam logic [AW:0] ROWS_W = (AW+1)'(ROWS);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_lat_d;
    logic [ROWS-1:0] r_lat_en;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_addr_ok;
    logic [ROWS-1:0] w_gate;

    assign w_addr_ok = ({1'b0, in_addr} < ROWS_W);
    assign w_gate    = ROWS'(1) << r_addr;

    // The counter is loaded with (phase length - 1) on entry; a phase ends when it reads zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_lat_d  <= '0;
            r_lat_en <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_addr_ok) begin
                            r_addr  <= in_addr;
                            r_lat_d <= in_data;
                            r_busy  <= 1'b1;
                            r_cnt   <= CW'(SETUP_CYC - 1);
                            r_state <= SETUP;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_lat_en <= w_gate;
                        r_cnt    <= CW'(PULSE_CYC - 1);
                        r_state  <= PULSE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_lat_en <= '0;
                        r_cnt    <= CW'(HOLD_CYC - 1);
                        r_state  <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_lat_en <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == IDLE);
    assign LAT_D    = r_lat_d;
    assign LAT_EN   = r_lat_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_dlat_bank_writer.sv
// Directed + randomized bench for dlat_bank_writer: two instances (default and
// stretched phase timing) checked against a per-write timing model and a latch-bank model.
module tb_dlat_bank_writer;

    localparam int DW   = 8;
    localparam int ROWS = 16;
    localparam int AW   = 5;
    localparam int SC [2] = '{1, 2};
    localparam int PC [2] = '{1, 3};
    localparam int HC [2] = '{1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]               rst;
    logic [1:0]               in_valid;
    logic [1:0][AW-1:0]       in_addr;
    logic [1:0][DW-1:0]       in_data;
    wire  [1:0]               in_ready;
    wire  [1:0]               busy;
    wire  [1:0]               done;
    wire  [1:0]               err;
    wire  [1:0][DW-1:0]       lat_d;
    wire  [1:0][ROWS-1:0]     lat_en;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dlat_bank_writer #(
            .DW(DW), .ROWS(ROWS), .AW(AW),
            .SETUP_CYC(SC[g]), .PULSE_CYC(PC[g]), .HOLD_CYC(HC[g])
        ) u_dut (
            .CLK(clk), .RST(rst[g]),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_addr(in_addr[g]), .in_data(in_data[g]),
            .LAT_D(lat_d[g]), .LAT_EN(lat_en[g]),
            .busy(busy[g]), .done(done[g]), .err(err[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural latch bank plus bus-protocol watchdog.
    logic [1:0][ROWS-1:0][DW-1:0] bank     = '0;
    logic [1:0][ROWS-1:0][DW-1:0] exp_bank = '0;
    logic [1:0][DW-1:0]           exp_d    = '0;
    logic [1:0][DW-1:0]           prev_d   = '0;
    logic [1:0][ROWS-1:0]         prev_en  = '0;
    logic [1:0]                   rst_q    = '0;
    int viol [2] = '{0, 0};

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!$onehot0(lat_en[k])) viol[k]++;
            if (!rst_q[k] && (lat_en[k] != '0 || prev_en[k] != '0) && lat_d[k] != prev_d[k]) viol[k]++;
            for (int r = 0; r < ROWS; r++) if (lat_en[k][r]) bank[k][r] = lat_d[k];
            prev_d[k]  = lat_d[k];
            prev_en[k] = lat_en[k];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input int k, input int a, input logic [DW-1:0] d);
        in_valid[k] = 1'b1;
        in_addr[k]  = AW'(a);
        in_data[k]  = d;
    endtask

    task automatic wait_ready(input int k);
        for (int t = 0; t < 50 && !in_ready[k]; t++) @(negedge clk);
        chk($sformatf("ready%0d", k), 128'(in_ready[k]), 128'd1);
    endtask

    // Full expected waveform of one valid write, relative to its accept edge.
    task automatic track(input int k, input int a, input logic [DW-1:0] d,
                         input bit last, input bit jitter, output int acc);
        int L;
        logic [27:0] e;
        L = SC[k] + PC[k] + HC[k] + 1;
        wait_ready(k);
        acc = cyc;
        exp_bank[k][a] = d;
        exp_d[k] = d;
        @(posedge clk);
        for (int n = 1; n <= L; n++) begin
            @(negedge clk);
            e = {d, (n > SC[k] && n <= SC[k] + PC[k]) ? 16'(1 << a) : 16'h0,
                 1'(n < L), 1'(n == L), 1'(n == L), 1'b0};
            chk($sformatf("wr%0d_a%0d_n%0d", k, a, n),
                128'({lat_d[k], lat_en[k], busy[k], done[k], in_ready[k], err[k]}), 128'(e));
            if (n == 1 && last) in_valid[k] = 1'b0;
            if (jitter && n < L) in_data[k] = DW'($urandom);
        end
    endtask

    task automatic track_err(input int k);
        wait_ready(k);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("err%0d_pulse", k),
            128'({lat_d[k], lat_en[k], busy[k], done[k], in_ready[k], err[k]}),
            128'({exp_d[k], 16'h0, 4'b0011}));
        in_valid[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("err%0d_after", k),
            128'({lat_d[k], lat_en[k], busy[k], done[k], in_ready[k], err[k]}),
            128'({exp_d[k], 16'h0, 4'b0010}));
    endtask

    initial begin
        int acc0, acc1, acc2, a;
        logic [DW-1:0] d;

        rst = 2'b11; in_valid = '0; in_addr = '0; in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 2'b00;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset%0d", k),
                128'({lat_d[k], lat_en[k], busy[k], done[k], in_ready[k], err[k]}),
                128'({8'h00, 16'h0, 4'b0010}));

        // Single write with default timing, then stretched timing to the top row.
        present(0, 3, 8'hA5);
        track(0, 3, 8'hA5, 1'b1, 1'b0, acc0);
        chk("bank0_first", 128'(bank[0]), 128'(exp_bank[0]));
        present(1, 15, 8'h3C);
        track(1, 15, 8'h3C, 1'b1, 1'b0, acc0);
        chk("bank1_row15", 128'(bank[1][15]), 128'h3C);

        // Back-to-back with in_valid held high.
        present(0, 0, 8'h11);
        track(0, 0, 8'h11, 1'b0, 1'b0, acc0);
        present(0, 1, 8'h22);
        track(0, 1, 8'h22, 1'b0, 1'b0, acc1);
        present(0, 2, 8'h33);
        track(0, 2, 8'h33, 1'b1, 1'b0, acc2);
        chk("b2b_gap1", 128'(acc1 - acc0), 128'd4);
        chk("b2b_gap2", 128'(acc2 - acc1), 128'd4);
        chk("bank0_b2b", 128'(bank[0]), 128'(exp_bank[0]));

        // Out-of-range address.
        present(0, 16, 8'h77);
        track_err(0);

        // Reset while the gate of row 5 is high.
        present(0, 5, 8'hC3);
        wait_ready(0);
        @(posedge clk);
        repeat (SC[0] + 1) @(negedge clk);
        in_valid[0] = 1'b0;
        chk("rst_in_pulse_gate", 128'(lat_en[0]), 128'(16'h0020));
        rst[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_op",
            128'({lat_d[0], lat_en[0], busy[0], done[0], in_ready[0], err[0]}),
            128'({8'h00, 16'h0, 4'b0010}));
        rst[0] = 1'b0;
        exp_d[0] = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("rst_no_done%0d", n), 128'({busy[0], done[0]}), 128'd0);
        end
        present(0, 5, 8'h5A);
        track(0, 5, 8'h5A, 1'b1, 1'b0, acc0);
        chk("bank0_row5", 128'(bank[0][5]), 128'h5A);

        // Changing data while busy must not leak onto the bus; next accept takes live data.
        present(1, 7, 8'h99);
        track(1, 7, 8'h99, 1'b0, 1'b1, acc0);
        present(1, 8, 8'h42);
        track(1, 8, 8'h42, 1'b1, 1'b0, acc0);

        // Randomized traffic on both instances, including illegal addresses.
        for (int i = 0; i < 16; i++) begin
            int k;
            k = i % 2;
            a = int'($urandom_range(0, 19));
            d = DW'($urandom);
            present(k, a, d);
            if (a < ROWS) track(k, a, d, 1'b1, 1'b0, acc0);
            else track_err(k);
        end

        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("bank_final%0d", k), 128'(bank[k]), 128'(exp_bank[k]));
            chk($sformatf("protocol%0d", k), 128'(viol[k]), 128'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
